// File: rtl/xnor_sync_scrambler.sv
// Serial self-synchronizing XNOR scrambler/descrambler with an idle-pattern
// lock checker (HUNT/SYNC/LOCKED) and a saturating mismatch counter.
module xnor_sync_scrambler #(
    parameter int LFSR_LEN = 7,
    parameter int TAP_A    = 7,
    parameter int TAP_B    = 6,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             MODE,
    input  logic             D,
    input  logic             CHK_EN,
    input  logic             EXP,
    output logic             Q,
    output logic             Q_VLD,
    output logic             LOCK,
    output logic [ERR_W-1:0] ERR_CNT,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int HW = $clog2(LFSR_LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_THR + 1);

    localparam logic [HW-1:0] HUNT_LAST  = HW'(LFSR_LEN - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THR - 1);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    state_t              state_reg;
    logic [LFSR_LEN-1:0] s_reg;
    logic [LFSR_LEN-1:0] s_next;
    logic [HW-1:0]       hunt_cnt_reg;
    logic [MW-1:0]       match_cnt_reg;
    logic [LW-1:0]       miss_cnt_reg;
    logic                y_next;
    logic                hit_next;
    wire                 unused_supply;

    // Supply pins exist only for the physical netlist.
    assign unused_supply = VDD ^ VSS;

    assign y_next   = ~(D ^ s_reg[TAP_A-1] ^ s_reg[TAP_B-1]);
    assign hit_next = (y_next == EXP);

    // Scrambler shifts in its own output; descrambler shifts in the line bit.
    assign s_next[0] = MODE ? D : y_next;
    genvar gi;
    generate
        for (gi = 1; gi < LFSR_LEN; gi++) begin : g_shift
            assign s_next[gi] = s_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_reg         <= '0;
            Q             <= 1'b0;
            Q_VLD         <= 1'b0;
            LOCK          <= 1'b0;
            ERR_CNT       <= '0;
            state_reg     <= HUNT;
            hunt_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            Q_VLD <= EN;
            if (EN) begin
                Q     <= y_next;
                s_reg <= s_next;
            end

            // The checker is only meaningful on descrambled data with CHK_EN.
            if (!(MODE && CHK_EN)) begin
                state_reg     <= HUNT;
                LOCK          <= 1'b0;
                hunt_cnt_reg  <= '0;
                match_cnt_reg <= '0;
                miss_cnt_reg  <= '0;
            end else if (EN) begin
                case (state_reg)
                    HUNT: begin
                        if (hunt_cnt_reg == HUNT_LAST) begin
                            state_reg     <= SYNC;
                            hunt_cnt_reg  <= '0;
                            match_cnt_reg <= '0;
                        end else begin
                            hunt_cnt_reg <= hunt_cnt_reg + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (hit_next) begin
                            if (match_cnt_reg == MATCH_LAST) begin
                                state_reg     <= LOCKED;
                                LOCK          <= 1'b1;
                                match_cnt_reg <= '0;
                                miss_cnt_reg  <= '0;
                            end else begin
                                match_cnt_reg <= match_cnt_reg + 1'b1;
                            end
                        end else begin
                            match_cnt_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!hit_next) begin
                            if (ERR_CNT != '1) begin
                                ERR_CNT <= ERR_CNT + 1'b1;
                            end
                            if (miss_cnt_reg == MISS_LAST) begin
                                state_reg    <= HUNT;
                                LOCK         <= 1'b0;
                                miss_cnt_reg <= '0;
                                hunt_cnt_reg <= '0;
                            end else begin
                                miss_cnt_reg <= miss_cnt_reg + 1'b1;
                            end
                        end else begin
                            miss_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= HUNT;
                        LOCK      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xnor_sync_scrambler.sv
// Directed bench: scrambler output, loopback, lock/error/loss behaviour and
// counter saturation, checked against a bit-level model and a scoreboard.
module tb_xnor_sync_scrambler;

    localparam int TA = 7;
    localparam int TB = 6;

    logic        clk;
    logic        rst, en, mode, d, chk, ex;
    logic        a_q, a_q_vld, a_lock;
    logic [15:0] a_err;
    logic        b_q, b_q_vld, b_lock;
    logic [15:0] b_err;
    logic        c_q, c_q_vld, c_lock;
    logic [3:0]  c_err;
    wire         vdd;
    wire         vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    xnor_sync_scrambler u_a (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .D(d), .CHK_EN(chk), .EXP(ex),
        .Q(a_q), .Q_VLD(a_q_vld), .LOCK(a_lock), .ERR_CNT(a_err), .VDD(vdd), .VSS(vss)
    );

    // Descrambler fed directly by the scrambler for the loopback test.
    xnor_sync_scrambler u_b (
        .CLK(clk), .RST(rst), .EN(a_q_vld), .MODE(1'b1), .D(a_q), .CHK_EN(1'b0), .EXP(1'b0),
        .Q(b_q), .Q_VLD(b_q_vld), .LOCK(b_lock), .ERR_CNT(b_err), .VDD(vdd), .VSS(vss)
    );

    // Narrow error counter instance sharing the stimulus of u_a.
    xnor_sync_scrambler #(.ERR_W(4)) u_c (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .D(d), .CHK_EN(chk), .EXP(ex),
        .Q(c_q), .Q_VLD(c_q_vld), .LOCK(c_lock), .ERR_CNT(c_err), .VDD(vdd), .VSS(vss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic loop_on;
    logic [6:0] ms;
    logic [6:0] gs;
    logic qa[$];
    logic qb[$];

    task automatic chk1(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: got %b, want %b", tag, got, want);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Next bit of a scrambled all-zeros stream.
    task automatic next_scr(output logic b);
        b  = ~(gs[TA-1] ^ gs[TB-1]);
        gs = {gs[5:0], b};
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic dd,
                        input logic ce, input logic xe);
        logic y, want, want_vld;
        rst = r; en = e; mode = m; d = dd; chk = ce; ex = xe;
        want_vld = 1'b0;
        if (r) begin
            ms = '0;
            qa.delete();
            qb.delete();
        end else if (e) begin
            y  = ~(dd ^ ms[TA-1] ^ ms[TB-1]);
            ms = {ms[5:0], (m ? dd : y)};
            qa.push_back(y);
            if (!m && loop_on) qb.push_back(dd);
            want_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        chk1("q_vld", a_q_vld, want_vld);
        chk1("c_q_vld", c_q_vld, want_vld);
        if (r) begin
            chk1("rst_q", a_q, 1'b0);
            chk1("rst_lock", a_lock, 1'b0);
            chk16("rst_err", a_err, 16'd0);
            chk16("rst_c_err", {12'b0, c_err}, 16'd0);
        end else if (want_vld) begin
            want = qa.pop_front();
            chk1("q", a_q, want);
            chk1("c_q", c_q, want);
        end
        if (loop_on && b_q_vld === 1'b1) begin
            chk1("loop_nonempty", qb.size() != 0, 1'b1);
            if (qb.size() != 0) begin
                want = qb.pop_front();
                chk1("loop_q", b_q, want);
            end
        end
    endtask

    initial begin
        logic [6:0]  pat;
        logic [15:0] w;
        logic        b;
        loop_on = 1'b1;
        ms = '0;
        gs = '0;

        // Reset, then scramble zeros; first seven outputs are 1111110.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (i < 7) pat = {pat[5:0], a_q};
            if (i == 10) step(0, 0, 0, 0, 0, 0);
        end
        chk16("first7", {9'b0, pat}, 16'h007E);

        // Loopback of a random stream with EN gaps.
        for (int i = 0; i < 200; i++) begin
            step(0, 1, 0, 1'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) step(0, 0, 0, 0, 0, 0);
            end
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk1("loop_drained", qb.size() == 0, 1'b1);
        chk1("b_lock", b_lock, 1'b0);
        chk16("b_err", b_err, 16'd0);
        loop_on = 1'b0;

        // Lock on a clean descrambled idle stream: 7 hunt + 16 sync bits.
        step(1, 0, 1, 0, 1, 0);
        gs = '0;
        for (int i = 1; i <= 30; i++) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 0);
            chk1($sformatf("lock_%0d", i), a_lock, (i >= 23));
        end
        chk16("err_after_lock", a_err, 16'd0);

        // Single line-bit error: mismatches at offsets 0, 6, 7.
        for (int k = 0; k < 10; k++) begin
            next_scr(b);
            step(0, 1, 1, b ^ (k == 0), 1, 0);
            chk1($sformatf("err_bit_%0d", k), a_q, (k == 0 || k == 6 || k == 7));
            chk1($sformatf("lock_hold_%0d", k), a_lock, 1'b1);
        end
        chk16("err_single", a_err, 16'd3);

        // Four consecutive mismatches drop lock; relock after 23 clean bits.
        repeat (3) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 0);
        end
        for (int j = 1; j <= 4; j++) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 1);
            chk1($sformatf("loss_%0d", j), a_lock, (j < 4));
        end
        chk16("err_loss", a_err, 16'd7);
        for (int i = 1; i <= 30; i++) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 0);
            chk1($sformatf("relock_%0d", i), a_lock, (i >= 23));
        end

        // CHK_EN drop while locked clears LOCK on the next edge; ERR_CNT holds.
        step(0, 0, 1, 0, 0, 0);
        chk1("chk_drop_lock", a_lock, 1'b0);
        chk16("chk_drop_err", a_err, 16'd7);
        for (int i = 1; i <= 30; i++) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 0);
            chk1($sformatf("relock2_%0d", i), a_lock, (i >= 23));
        end

        // Saturation of the 4-bit counter: 20 isolated mismatches from 7.
        for (int n = 1; n <= 20; n++) begin
            next_scr(b);
            step(0, 1, 1, b, 1, 1);
            w = (7 + n > 15) ? 16'd15 : 16'(7 + n);
            chk16($sformatf("sat_%0d", n), {12'b0, c_err}, w);
            chk1($sformatf("sat_lock_%0d", n), c_lock, 1'b1);
            next_scr(b);
            step(0, 1, 1, b, 1, 0);
        end
        chk16("err_wide", a_err, 16'd27);

        // Reset together with EN, then prove the register restarted at zero.
        step(1, 1, 0, 1, 1, 0);
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 0, 0, 0);
            pat = {pat[5:0], a_q};
        end
        chk16("post_rst_first7", {9'b0, pat}, 16'h007E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
